dcache_sram_bwe: RTL and testbench

//  Parametrised single-port, byte-write-enable synchronous SRAM for DCache data/tag arrays.

---
 rtl/dcache_pkg.sv | 6 +
 rtl/dcache_ram_clr_ctr.sv | 20 ++
 rtl/dcache_sram_bwe.sv | 64 ++++++
 tb/tb_dcache_sram_bwe.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and constants for the DCache SRAM arrays
package dcache_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic {RAM_READ_HOLD, RAM_WRITE_FIRST} ram_mode_e;
  typedef enum logic {RAM_CLEAR, RAM_IDLE} ram_state_e;
endpackage

// File: rtl/dcache_ram_clr_ctr.sv
// dcache_ram_clr_ctr: entry counter for the array clear sequence
module dcache_ram_clr_ctr #(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_restart,
  input  logic          i_en,
  output logic [AW-1:0] o_ctr,
  output logic          o_done
);
  logic [AW-1:0] r_ctr;
  assign o_ctr  = r_ctr;
  assign o_done = i_en & (r_ctr == AW'(DEPTH - 1));
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_ctr <= '0;
    else if (i_restart) r_ctr <= '0;
    else if (i_en) r_ctr <= o_done ? '0 : r_ctr + 1'b1;
endmodule

// File: rtl/dcache_sram_bwe.sv
// dcache_sram_bwe: single-port byte-write-enable SRAM with hardware clear sequencer
module dcache_sram_bwe
  import dcache_pkg::*;
#(
  parameter int DW = 32,
  parameter int DEPTH = 256,
  parameter bit WRITE_FIRST = 1'b0,
  parameter logic [DW-1:0] CLR_VAL = '0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_init,
  input  logic               i_ena,
  input  logic [DW/8-1:0]    i_wea,
  input  logic [AW-1:0]      i_addra,
  input  logic [DW-1:0]      i_dina,
  output logic [DW-1:0]      o_douta,
  output logic               o_dvalid,
  output logic               o_ready
);
  localparam int NB = DW / BYTE_W;
  localparam ram_mode_e MODE = WRITE_FIRST ? RAM_WRITE_FIRST : RAM_READ_HOLD;
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_douta, w_old, w_merged;
  logic          r_dvalid, w_clearing, w_acc, w_wr, w_in, w_done, w_upd;
  logic [AW-1:0] w_ctr;
  ram_state_e    r_state, w_next;
  assign w_clearing = r_state == RAM_CLEAR;
  assign w_acc      = ~w_clearing & i_ena;
  assign w_wr       = w_acc & |i_wea;
  assign w_in       = {1'b0, i_addra} < (AW + 1)'(DEPTH);
  assign w_old      = w_in ? r_mem[i_addra] : '0;
  assign w_upd      = w_acc & (~w_wr | MODE == RAM_WRITE_FIRST);
  assign o_douta    = r_douta;
  assign o_dvalid   = r_dvalid;
  assign o_ready    = ~w_clearing;
  dcache_ram_clr_ctr #(.DEPTH(DEPTH)) u_clr (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_restart(i_init), .i_en(w_clearing),
    .o_ctr(w_ctr), .o_done(w_done)
  );
  always_comb begin
    w_merged = w_old;
    for (int b = 0; b < NB; b++)
      if (i_wea[b]) w_merged[b*BYTE_W +: BYTE_W] = i_dina[b*BYTE_W +: BYTE_W];
  end
  always_comb begin
    w_next = i_init ? RAM_CLEAR : (w_done ? RAM_IDLE : r_state);
  end
  // Storage stays reset-free so it maps onto RAM primitives
  always_ff @(posedge i_clk)
    if (w_clearing) r_mem[w_ctr] <= CLR_VAL;
    else if (w_wr && w_in) r_mem[i_addra] <= w_merged;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state  <= RAM_CLEAR;
      r_douta  <= '0;
      r_dvalid <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_dvalid <= w_upd;
      if (w_upd) r_douta <= w_wr ? w_merged : w_old;
    end
endmodule

// File: tb/tb_dcache_sram_bwe.sv
// tb_dcache_sram_bwe: table-driven scoreboard bench for read-hold, write-first and odd-depth instances
module tb_dcache_sram_bwe;
  logic        clk = 1'b0, rst_n = 1'b0, init = 1'b0, ena = 1'b0;
  logic [3:0]  wea = '0;
  logic [7:0]  addr = '0;
  logic [31:0] din = '0;
  logic [31:0] dout0, dout1;
  logic        dv0, dv1, rdy0, rdy1;
  logic        ena2 = 1'b0;
  logic [7:0]  wea2 = '0, addr2 = '0;
  logic [63:0] din2 = '0, dout2;
  logic        dv2, rdy2;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  dcache_sram_bwe #(.DW(32), .DEPTH(256), .WRITE_FIRST(1'b0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_init(init), .i_ena(ena), .i_wea(wea), .i_addra(addr),
    .i_dina(din), .o_douta(dout0), .o_dvalid(dv0), .o_ready(rdy0));
  dcache_sram_bwe #(.DW(32), .DEPTH(256), .WRITE_FIRST(1'b1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_init(init), .i_ena(ena), .i_wea(wea), .i_addra(addr),
    .i_dina(din), .o_douta(dout1), .o_dvalid(dv1), .o_ready(rdy1));
  dcache_sram_bwe #(.DW(64), .DEPTH(200), .WRITE_FIRST(1'b0), .CLR_VAL({64{1'b1}})) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_init(1'b0), .i_ena(ena2), .i_wea(wea2), .i_addra(addr2),
    .i_dina(din2), .o_douta(dout2), .o_dvalid(dv2), .o_ready(rdy2));

  typedef struct {
    logic [31:0] e0; logic v0; logic [31:0] e1; logic v1; string nm;
  } exp_t;
  typedef struct {
    logic en; logic [3:0] we; logic [7:0] a; logic [31:0] d;
    logic [31:0] e0; logic v0; logic [31:0] e1; logic v1;
  } vec_t;
  exp_t q[$];
  vec_t tv[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Drive one access to dut0/dut1 at a falling edge, compare one cycle later
  task automatic acc(input logic en, input logic [3:0] we, input logic [7:0] a, input logic [31:0] d,
                     input logic [31:0] e0, input logic v0, input logic [31:0] e1, input logic v1,
                     input string nm);
    exp_t e;
    ena = en; wea = we; addr = a; din = d;
    q.push_back('{e0, v0, e1, v1, nm});
    @(negedge clk);
    e = q.pop_front();
    chk({e.nm, "_dout0"}, {32'h0, dout0}, {32'h0, e.e0});
    chk({e.nm, "_dv0"}, {63'h0, dv0}, {63'h0, e.v0});
    chk({e.nm, "_dout1"}, {32'h0, dout1}, {32'h0, e.e1});
    chk({e.nm, "_dv1"}, {63'h0, dv1}, {63'h0, e.v1});
    ena = 1'b0; wea = '0;
  endtask

  task automatic acc2(input logic [7:0] we, input logic [7:0] a, input logic [63:0] d,
                      input logic [63:0] e, input logic v, input string nm);
    ena2 = 1'b1; wea2 = we; addr2 = a; din2 = d;
    @(negedge clk);
    chk({nm, "_dout2"}, dout2, e);
    chk({nm, "_dv2"}, {63'h0, dv2}, {63'h0, v});
    ena2 = 1'b0; wea2 = '0;
  endtask

  // Count rising edges until dut0/dut1 become ready; also note when dut2 does
  task automatic wait_ready(input string nm, input int exp_n, input logic chk2);
    int n = 0, n2 = 0, bad = 0;
    while (!(rdy0 && rdy1) && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (rdy2 && n2 == 0) n2 = n;
      if (dv0 || dv1) bad++;
    end
    chk({nm, "_ready_cycles"}, 64'(n), 64'(exp_n));
    chk({nm, "_no_dvalid"}, 64'(bad), 64'd0);
    if (chk2) chk({nm, "_ready2_cycles"}, 64'(n2), 64'd200);
    @(negedge clk);
  endtask

  initial begin
    tv[0]  = '{1, 4'b1111, 8'd3,   32'hA5A5A5A5, 32'h0,        0, 32'hA5A5A5A5, 1};
    tv[1]  = '{1, 4'b0101, 8'd3,   32'h11223344, 32'h0,        0, 32'hA522A544, 1};
    tv[2]  = '{1, 4'b0000, 8'd3,   32'h0,        32'hA522A544, 1, 32'hA522A544, 1};
    tv[3]  = '{1, 4'b1111, 8'd7,   32'hDEADBEEF, 32'hA522A544, 0, 32'hDEADBEEF, 1};
    tv[4]  = '{1, 4'b0000, 8'd7,   32'h0,        32'hDEADBEEF, 1, 32'hDEADBEEF, 1};
    tv[5]  = '{0, 4'b1111, 8'd7,   32'h55555555, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0};
    tv[6]  = '{1, 4'b0011, 8'd9,   32'h1234CAFE, 32'hDEADBEEF, 0, 32'h0000CAFE, 1};
    tv[7]  = '{1, 4'b0000, 8'd9,   32'h0,        32'h0000CAFE, 1, 32'h0000CAFE, 1};
    tv[8]  = '{1, 4'b1000, 8'd255, 32'h77665544, 32'h0000CAFE, 0, 32'h77000000, 1};
    tv[9]  = '{1, 4'b0000, 8'd255, 32'h0,        32'h77000000, 1, 32'h77000000, 1};
    tv[10] = '{1, 4'b0000, 8'd3,   32'h0,        32'hA522A544, 1, 32'hA522A544, 1};
    #12;
    chk("rst_dout0", {32'h0, dout0}, 64'h0);
    chk("rst_dv0", {63'h0, dv0}, 64'h0);
    chk("rst_ready0", {63'h0, rdy0}, 64'h0);
    chk("rst_ready2", {63'h0, rdy2}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("boot", 256, 1'b1);
    for (int i = 0; i < 256; i++) acc(1, 4'h0, 8'(i), 32'h0, 32'h0, 1, 32'h0, 1, "clr_rd");
    acc2(8'h00, 8'd199, 64'h0, {64{1'b1}}, 1, "d2_rd199");
    acc2(8'hFF, 8'd210, 64'h0123456789ABCDEF, {64{1'b1}}, 0, "d2_wr210");
    acc2(8'h00, 8'd210, 64'h0, 64'h0, 1, "d2_rd210");
    acc2(8'h0F, 8'd150, 64'h0123456789ABCDEF, 64'h0, 0, "d2_wr150");
    acc2(8'h00, 8'd150, 64'h0, 64'hFFFFFFFF89ABCDEF, 1, "d2_rd150");
    acc2(8'h00, 8'd0, 64'h0, {64{1'b1}}, 1, "d2_rd0");
    for (int i = 0; i < 11; i++)
      acc(tv[i].en, tv[i].we, tv[i].a, tv[i].d, tv[i].e0, tv[i].v0, tv[i].e1, tv[i].v1,
          $sformatf("vec%0d", i));
    init = 1'b1;
    @(negedge clk);
    init = 1'b0; ena = 1'b1; wea = '0; addr = 8'd9;
    chk("init_ready_low", {63'h0, rdy0}, 64'h0);
    wait_ready("init", 256, 1'b0);
    ena = 1'b0;
    acc(1, 4'h0, 8'd9, 32'h0, 32'h0, 1, 32'h0, 1, "post_init_rd9");
    acc(1, 4'hF, 8'd5, 32'h12345678, 32'h0, 0, 32'h12345678, 1, "wr5");
    acc(1, 4'h0, 8'd5, 32'h0, 32'h12345678, 1, 32'h12345678, 1, "rd5");
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midclr_dout0", {32'h0, dout0}, 64'h0);
    chk("midclr_dout1", {32'h0, dout1}, 64'h0);
    chk("midclr_ready0", {63'h0, rdy0}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("reboot", 256, 1'b1);
    acc(1, 4'h0, 8'd5, 32'h0, 32'h0, 1, 32'h0, 1, "reboot_rd5");
    acc2(8'h00, 8'd150, 64'h0, {64{1'b1}}, 1, "d2_reboot_rd150");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
